// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter that shares a single-port data memory
// between port 0 (CPU load/store) and port 1 (loader/DMA/debug). Each grant
// captures one command, drives the memory for exactly one cycle, then returns
// a registered ack/err/rdata to the granted port. Misaligned commands are
// granted but never reach the memory. A saturating counter records every
// grant where both ports competed.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  // port 0
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  // port 1
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  // data memory
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  // performance debug
  output logic [CNT_W-1:0]  conflict_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e            state_q;
  logic              last_q;       // port granted most recently
  logic              sel_q;        // port being served
  logic              mis_q;        // captured command is misaligned
  logic              m0_ack_q, m0_err_q;
  logic              m1_ack_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              mem_write_q, mem_read_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] write_data_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              elig0_d, elig1_d, both_elig_d, gnt_valid_d, gnt_sel_d;
  logic              gnt_we_d, gnt_mis_d;
  logic [ADDR_W-1:0] gnt_addr_d;
  logic [DATA_W-1:0] gnt_wdata_d;

  // Arbitration: a port whose ack is high this cycle is masked so the same
  // command is not served twice; ties go to the port that did not win last.
  always_comb begin
    elig0_d     = m0_req & ~m0_ack_q;
    elig1_d     = m1_req & ~m1_ack_q;
    both_elig_d = elig0_d & elig1_d;
    gnt_valid_d = elig0_d | elig1_d;
    gnt_sel_d   = both_elig_d ? ~last_q : elig1_d;
    gnt_we_d    = gnt_sel_d ? m1_we    : m0_we;
    gnt_addr_d  = gnt_sel_d ? m1_addr  : m0_addr;
    gnt_wdata_d = gnt_sel_d ? m1_wdata : m0_wdata;
    gnt_mis_d   = (gnt_addr_d[1:0] != 2'b00);
  end

  // Grant/serve FSM with registered memory lines and per-port responses.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      sel_q        <= 1'b0;
      mis_q        <= 1'b0;
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      m1_rdata_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      cnt_q        <= '0;
    end else begin
      // acks are single-cycle pulses
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid_d) begin
            sel_q        <= gnt_sel_d;
            last_q       <= gnt_sel_d;
            mis_q        <= gnt_mis_d;
            // a misaligned command never touches the memory
            mem_write_q  <= gnt_we_d & ~gnt_mis_d;
            mem_read_q   <= ~gnt_we_d & ~gnt_mis_d;
            address_q    <= gnt_mis_d ? '0 : gnt_addr_d;
            write_data_q <= gnt_mis_d ? '0 : gnt_wdata_d;
            if (both_elig_d && (cnt_q != '1)) begin
              cnt_q <= cnt_q + 1'b1;
            end
            state_q <= SERVE;
          end
        end
        SERVE: begin
          mem_write_q  <= 1'b0;
          mem_read_q   <= 1'b0;
          address_q    <= '0;
          write_data_q <= '0;
          if (sel_q) begin
            m1_ack_q   <= 1'b1;
            m1_err_q   <= mis_q;
            m1_rdata_q <= mem_read_q ? read_data : '0;
          end else begin
            m0_ack_q   <= 1'b1;
            m0_err_q   <= mis_q;
            m0_rdata_q <= mem_read_q ? read_data : '0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_ack         = m0_ack_q;
  assign m0_err         = m0_err_q;
  assign m0_rdata       = m0_rdata_q;
  assign m1_ack         = m1_ack_q;
  assign m1_err         = m1_err_q;
  assign m1_rdata       = m1_rdata_q;
  assign MemWrite       = mem_write_q;
  assign MemRead        = mem_read_q;
  assign address        = address_q;
  assign write_data     = write_data_q;
  assign conflict_count = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small
// behavioural data memory (combinational read, posedge write). Built with a
// 4-bit conflict counter so saturation is reachable quickly.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m0_ack, m0_err;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_ack, m1_err;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              MemWrite, MemRead;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data, read_data;
  logic [CNT_W-1:0]  conflict_count;

  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_req        (m0_req),
    .m0_we         (m0_we),
    .m0_addr       (m0_addr),
    .m0_wdata      (m0_wdata),
    .m0_ack        (m0_ack),
    .m0_err        (m0_err),
    .m0_rdata      (m0_rdata),
    .m1_req        (m1_req),
    .m1_we         (m1_we),
    .m1_addr       (m1_addr),
    .m1_wdata      (m1_wdata),
    .m1_ack        (m1_ack),
    .m1_err        (m1_err),
    .m1_rdata      (m1_rdata),
    .MemWrite      (MemWrite),
    .MemRead       (MemRead),
    .address       (address),
    .write_data    (write_data),
    .read_data     (read_data),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // data memory: write on posedge, combinational read
  always @(posedge clk) begin
    if (MemWrite) mem[address[7:2]] <= write_data;
  end
  assign read_data = mem[address[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // one complete port-0 transaction with every step checked
  task automatic m0_op(input string tag, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rdata);
    logic ok;
    ok       = (a[1:0] == 2'b00);
    m0_req   = 1'b1;
    m0_we    = we;
    m0_addr  = a;
    m0_wdata = d;
    tick();
    check({tag, " MemWrite"}, MemWrite, (we && ok));
    check({tag, " MemRead"},  MemRead,  (!we && ok));
    check({tag, " address"},  address,  ok ? a : 32'h0);
    if (ok) check({tag, " write_data"}, write_data, d);
    check({tag, " ack early"}, m0_ack, 1'b0);
    tick();
    check({tag, " ack"},      m0_ack,   1'b1);
    check({tag, " err"},      m0_err,   !ok);
    check({tag, " rdata"},    m0_rdata, exp_rdata);
    check({tag, " MemWrite off"}, MemWrite, 1'b0);
    m0_req = 1'b0;
    tick();
    check({tag, " ack pulse"},  m0_ack,   1'b0);
    check({tag, " rdata hold"}, m0_rdata, exp_rdata);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    // reset state
    do_reset();
    check("rst m0_ack",   m0_ack, 1'b0);
    check("rst m1_ack",   m1_ack, 1'b0);
    check("rst m0_rdata", m0_rdata, 32'h0);
    check("rst MemWrite", MemWrite, 1'b0);
    check("rst MemRead",  MemRead, 1'b0);
    check("rst address",  address, 32'h0);
    check("rst count",    conflict_count, 32'h0);

    // port 0 write then read of 0x10
    m0_op("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
    check("mem[0x10] after write", mem[4], 32'hDEAD_BEEF);
    m0_op("rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);

    // misaligned write must not touch memory; readback still old value
    m0_op("wr13", 1'b1, 32'h13, 32'hCAFE_F00D, 32'h0);
    check("mem[0x10] after misaligned", mem[4], 32'hDEAD_BEEF);
    m0_op("rd10b", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);

    // both ports request together: 0,1,0,1 with a single counted conflict
    do_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("alt address", address, (g % 2) ? 32'h4 : 32'h0);
      check("alt MemRead", MemRead, 1'b1);
      if (g == 0) check("alt first conflict", conflict_count, 32'h1);
      tick();
      check("alt m0_ack", m0_ack, ((g % 2) == 0));
      check("alt m1_ack", m1_ack, ((g % 2) == 1));
      check("alt rdata", (g % 2) ? m1_rdata : m0_rdata,
            (g % 2) ? 32'h2222_2222 : 32'h1111_1111);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    check("alt idle MemRead", MemRead, 1'b0);
    check("alt conflict total", conflict_count, 32'h1);

    // port 1 alone, back-to-back reads: acks 3 cycles apart
    do_reset();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("m1 seq address", address, 32'(4 * k));
      check("m1 seq MemRead", MemRead, 1'b1);
      tick();
      check("m1 seq ack", m1_ack, 1'b1);
      check("m1 seq rdata", m1_rdata,
            (k == 0) ? 32'h1111_1111 : (k == 1) ? 32'h2222_2222 : 32'h3333_3333);
      if (k < 2) m1_addr = 32'(4 * (k + 1));
      else       m1_req  = 1'b0;
      tick();
      check("m1 seq masked ack", m1_ack, 1'b0);
      check("m1 seq masked MemRead", MemRead, 1'b0);
    end
    tick();
    tick();
    check("m1 seq no extra ack", m1_ack, 1'b0);
    check("m1 seq count", conflict_count, 32'h0);

    // reset during SERVE of a port-1 write: write commits, no ack
    do_reset();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
    tick();
    check("rs MemWrite", MemWrite, 1'b1);
    check("rs address", address, 32'h20);
    reset = 1'b1;
    tick();
    check("rs no ack", m1_ack, 1'b0);
    check("rs MemWrite cleared", MemWrite, 1'b0);
    check("rs address cleared", address, 32'h0);
    check("rs mem committed", mem[8], 32'h1234_5678);
    tick();
    check("rs+req no grant MemWrite", MemWrite, 1'b0);
    check("rs+req no ack", m1_ack, 1'b0);
    m1_req = 1'b0;
    reset  = 1'b0;
    tick();
    check("rs after m1_ack", m1_ack, 1'b0);
    check("rs after m1_err", m1_err, 1'b0);
    check("rs after m1_rdata", m1_rdata, 32'h0);
    check("rs after count", conflict_count, 32'h0);
    m0_op("rd20", 1'b0, 32'h20, 32'h0, 32'h1234_5678);

    // 19 fresh conflicts: counter saturates at 0xF and holds
    do_reset();
    m0_we = 1'b0; m0_addr = 32'h0;
    m1_we = 1'b0; m1_addr = 32'h4;
    for (int r = 0; r < 19; r++) begin
      m0_req = 1'b1;
      m1_req = 1'b1;
      tick();
      tick();
      m0_req = 1'b0;
      m1_req = 1'b0;
      tick();
      check("sat count", conflict_count, (r + 1 > 15) ? 32'd15 : 32'(r + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store stage) and port 1 (loader/DMA/debug).
- Captures one command per grant, drives the memory control and address lines for exactly one cycle, and returns a registered ack with read data.
- Arbitration is round-robin. The block also rejects misaligned accesses and keeps a saturating conflict counter for performance debug.
- Sits between the requesters and the data memory (MemWrite/MemRead/address/write_data/read_data). The memory reads combinationally and writes on posedge clk.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 command valid; held with its fields stable until m0_ack.
- m0_we  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  port 0 byte address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_ack  out  1  port 0 one-cycle completion pulse.
- m0_err  out  1  port 0 misaligned-access flag, valid with m0_ack.
- m0_rdata  out  DATA_W  port 0 read data, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as port 0, for port 1.
- MemWrite  out  1  to data memory.
- MemRead  out  1  to data memory.
- address  out  ADDR_W  to data memory.
- write_data  out  DATA_W  to data memory.
- read_data  in  DATA_W  from data memory, combinational.
- conflict_count  out  CNT_W  saturating count of arbitration losses.

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high. Reset sets state=IDLE, last=1, all acks/errs=0, rdata=0, conflict_count=0.
- States:
  - IDLE: MemWrite=0, MemRead=0, address=0, write_data=0.
  - SERVE: memory lines are driven from the captured command.
- Eligibility in IDLE: mX is eligible if mX_req=1 and mX_ack=0 in the current cycle. The ack mask prevents re-serving a command whose requester has not yet dropped req.
- Grant in IDLE (at posedge):
  - Only one port eligible: grant it.
  - Both eligible: grant the port that is not `last`.
  - Then capture sel, we, addr, wdata, set last=sel, and go to SERVE.
- Misaligned command (addr[1:0]!=0): it is still granted. In SERVE it drives MemWrite=0, MemRead=0, address=0.
- SERVE, aligned command:
  - MemRead = ~we, MemWrite = we, address = captured addr, write_data = captured wdata.
- End of SERVE (next posedge):
  - The memory commits any write.
  - msel_rdata <= (aligned & ~we) ? read_data : 0.
  - msel_err <= misaligned.
  - msel_ack <= 1.
  - State returns to IDLE.
- Ack and rdata: ack is high for exactly one cycle. mX_rdata holds its value until that port's next ack; it is not cleared when ack falls.
- Latency: req sampled at edge E0 → memory access during cycle E0..E1 → ack high during E1..E2. A single port alone sustains one access per 3 cycles. With both ports active, grants alternate 0,1,0,1 and the total rate is one access per 2 cycles.
- Conflict counter: at each IDLE grant edge where both ports are eligible, conflict_count increments by 1 and saturates at all-ones.
- req dropped before ack: this is a protocol violation. The captured command still completes and acks.
- Reset in SERVE:
  - The memory samples MemWrite at the same edge, so an in-flight aligned write still commits.
  - No ack or err is produced; the next state is IDLE.
- Reset and req together: reset wins; no grant occurs at that edge.

Test Plan:
- Reset, then m0 write addr=0x10 data=0xDEADBEEF, then m0 read addr=0x10 → MemWrite high for exactly 1 cycle with address=0x10; read ack 2 cycles after its req edge with m0_rdata=0xDEADBEEF, m0_err=0.
- m0_req and m1_req both rise at the same edge after reset (reads of 0x0 and 0x4) → m0 served first, m1 next. Grants alternate 0,1,0,1 while both hold req; conflict_count=1 after the first grant.
- m1 alone issues back-to-back reads 0x0, 0x4, 0x8 → acks spaced 3 cycles apart; no second ack for a command after req drops; conflict_count stays 0.
- m0 write to addr=0x13 → MemWrite=0 throughout; m0_ack=1 and m0_err=1 together; m0_rdata=0; memory word 0x10 unchanged on readback.
- Assert reset during SERVE of an m1 write 0x20←0x12345678 → no m1_ack. Memory word at 0x20 reads 0x12345678 after reset. Outputs return to reset values.
- Force 2^CNT_W+3 conflicts (use CNT_W=4 build) → conflict_count saturates at 0xF and holds.
